// File: rtl/fade_interp.sv
// Per-channel complex fade interpolator: holds pending/next/prev coefficient banks
// and streams prev + (next-prev)*s/L for all channels on each sample tick.
module fade_interp #(
    parameter int          N       = 32,
    parameter int          LOG2_L  = 4,
    parameter int          W       = 16,
    parameter logic [24:0] T_RESET = '0   // reset value of the fader time index; 0 in normal use
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fade_dv,
    input  logic [$clog2(N)-1:0] fade_chan,
    input  logic signed [W-1:0]  fade_real,
    input  logic signed [W-1:0]  fade_imag,
    input  logic                 sample_tick,
    output logic                 fader_start,
    output logic [24:0]          fader_t_index,
    output logic                 out_valid,
    output logic [$clog2(N)-1:0] out_chan,
    output logic signed [W-1:0]  out_real,
    output logic signed [W-1:0]  out_imag,
    output logic                 underflow,
    output logic                 tick_err
);
    // state      | meaning
    // PRIME0     | waiting for the t=0 burst to fill pending
    // PRIME1     | waiting for the t=1 burst; then prev/next are valid
    // RUN_IDLE   | interpolating, waiting for sample_tick
    // RUN_STREAM | reading channels 0..N-1, then one update cycle
    typedef enum logic [1:0] {PRIME0, PRIME1, RUN_IDLE, RUN_STREAM} state_t;

    localparam int                CW    = $clog2(N);
    localparam logic [CW:0]       N_C   = (CW+1)'(N);
    localparam logic [LOG2_L-1:0] S_MAX = '1;

    state_t            state, state_nxt;
    logic              launched;
    logic [CW:0]       pend_cnt;
    logic [CW:0]       rd_idx;
    logic [LOG2_L-1:0] s;
    logic [24:0]       t_index;
    logic              pend_full;
    logic              do_start, load_next, rotate, inc_s, uf;

    logic [W-1:0] pend_re [N];
    logic [W-1:0] pend_im [N];
    logic [W-1:0] next_re [N];
    logic [W-1:0] next_im [N];
    logic [W-1:0] prev_re [N];
    logic [W-1:0] prev_im [N];

    assign pend_full     = (pend_cnt == N_C);
    assign fader_t_index = t_index;

    // floor((next-prev)*s / L) via arithmetic shift; result always lies between prev and next
    function automatic logic [W-1:0] interp(input logic [W-1:0] prev_v,
                                            input logic [W-1:0] next_v,
                                            input logic [LOG2_L-1:0] st);
        logic signed [W:0] diff;
        diff = $signed({next_v[W-1], next_v}) - $signed({prev_v[W-1], prev_v});
        return prev_v + W'(($signed({{LOG2_L{diff[W]}}, diff})
                           * $signed({{(W+1){1'b0}}, st})) >>> LOG2_L);
    endfunction

    always_comb begin
        state_nxt = state;
        do_start  = 1'b0;
        load_next = 1'b0;
        rotate    = 1'b0;
        inc_s     = 1'b0;
        uf        = 1'b0;
        case (state)
            PRIME0: begin
                if (!launched) begin
                    do_start = 1'b1;
                end else if (pend_full) begin
                    load_next = 1'b1;
                    do_start  = 1'b1;
                    state_nxt = PRIME1;
                end
            end
            PRIME1: begin
                if (pend_full) begin
                    rotate    = 1'b1;
                    do_start  = 1'b1;
                    state_nxt = RUN_IDLE;
                end
            end
            RUN_IDLE: begin
                if (sample_tick) state_nxt = RUN_STREAM;
            end
            RUN_STREAM: begin
                if (rd_idx == N_C) begin
                    state_nxt = RUN_IDLE;
                    if (s != S_MAX) begin
                        inc_s = 1'b1;
                    end else if (pend_full) begin
                        rotate   = 1'b1;
                        do_start = 1'b1;
                    end else begin
                        uf = 1'b1;
                    end
                end
            end
            default: state_nxt = PRIME0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= PRIME0;
            launched    <= 1'b0;
            pend_cnt    <= '0;
            rd_idx      <= '0;
            s           <= '0;
            t_index     <= T_RESET;
            fader_start <= 1'b0;
            underflow   <= 1'b0;
            tick_err    <= 1'b0;
            out_valid   <= 1'b0;
            out_chan    <= '0;
            out_real    <= '0;
            out_imag    <= '0;
            pend_re     <= '{default: '0};
            pend_im     <= '{default: '0};
            next_re     <= '{default: '0};
            next_im     <= '{default: '0};
            prev_re     <= '{default: '0};
            prev_im     <= '{default: '0};
        end else begin
            state       <= state_nxt;
            fader_start <= do_start;
            underflow   <= uf;
            tick_err    <= sample_tick && (state != RUN_IDLE);

            if (do_start) begin
                launched <= 1'b1;
                if (launched) t_index <= t_index + 25'd1;
            end

            // a result arriving with a start pulse belongs to the new fader request
            if (do_start)
                pend_cnt <= fade_dv ? (CW+1)'(1) : '0;
            else if (fade_dv && !pend_full)
                pend_cnt <= pend_cnt + 1'b1;

            // copies read the old pending bank, so a same-cycle write never reaches next
            if (fade_dv) begin
                pend_re[fade_chan] <= fade_real;
                pend_im[fade_chan] <= fade_imag;
            end
            if (load_next) begin
                next_re <= pend_re;
                next_im <= pend_im;
            end
            if (rotate) begin
                prev_re <= next_re;
                prev_im <= next_im;
                next_re <= pend_re;
                next_im <= pend_im;
                s       <= '0;
            end else if (inc_s) begin
                s <= s + 1'b1;
            end

            rd_idx    <= (state == RUN_STREAM) ? rd_idx + 1'b1 : '0;
            out_valid <= (state == RUN_STREAM) && (rd_idx < N_C);
            out_chan  <= rd_idx[CW-1:0];
            out_real  <= interp(prev_re[rd_idx[CW-1:0]], next_re[rd_idx[CW-1:0]], s);
            out_imag  <= interp(prev_im[rd_idx[CW-1:0]], next_im[rd_idx[CW-1:0]], s);
        end
    end
endmodule

// File: tb/tb_fade_interp.sv
// Scoreboard bench for fade_interp: priming, interpolation, underflow, tick drop,
// rotation corner cases, time-index wrap (second instance) and mid-frame reset.
module tb_fade_interp;
    localparam int          N  = 32;
    localparam logic [24:0] T2 = 25'h1FF_FFFD;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              fade_dv = 1'b0;
    logic [4:0]        fade_chan = '0;
    logic signed [15:0] fade_real = '0, fade_imag = '0;
    logic              sample_tick = 1'b0;

    logic              a_fader_start, a_out_valid, a_underflow, a_tick_err;
    logic [24:0]       a_fader_t_index;
    logic [4:0]        a_out_chan;
    logic signed [15:0] a_out_real, a_out_imag;
    logic              b_fader_start, b_out_valid, b_underflow, b_tick_err;
    logic [24:0]       b_fader_t_index;
    logic [4:0]        b_out_chan;
    logic signed [15:0] b_out_real, b_out_imag;

    fade_interp dut (
        .clk(clk), .reset(reset), .fade_dv(fade_dv), .fade_chan(fade_chan),
        .fade_real(fade_real), .fade_imag(fade_imag), .sample_tick(sample_tick),
        .fader_start(a_fader_start), .fader_t_index(a_fader_t_index),
        .out_valid(a_out_valid), .out_chan(a_out_chan), .out_real(a_out_real),
        .out_imag(a_out_imag), .underflow(a_underflow), .tick_err(a_tick_err)
    );

    // same stimulus, time index starting near the top so a wrap happens early
    fade_interp #(.T_RESET(T2)) dut_wrap (
        .clk(clk), .reset(reset), .fade_dv(fade_dv), .fade_chan(fade_chan),
        .fade_real(fade_real), .fade_imag(fade_imag), .sample_tick(sample_tick),
        .fader_start(b_fader_start), .fader_t_index(b_fader_t_index),
        .out_valid(b_out_valid), .out_chan(b_out_chan), .out_real(b_out_real),
        .out_imag(b_out_imag), .underflow(b_underflow), .tick_err(b_tick_err)
    );

    always #5 clk = ~clk;

    typedef struct {int cyc; int chan; int re; int im;} sb_entry_t;
    sb_entry_t sb [$];

    int cyc = 0;
    int n_tests = 0, n_fail = 0;
    int n_starts = 0, n_starts_wrap = 0, uf_cnt = 0;
    logic [24:0] exp_ti, exp_ti_wrap;
    int b_re [4][N];
    int b_im [4][N];
    int mp, mn, ms;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int fdiv16(input int q);
        if (q >= 0) return q / 16;
        return -((-q + 15) / 16);
    endfunction

    function automatic int interp_exp(input int p, input int n, input int st);
        return p + fdiv16((n - p) * st);
    endfunction

    always @(negedge clk) begin : monitor
        sb_entry_t e;
        if (!reset) begin
            if (a_out_valid) begin
                if (sb.size() == 0) begin
                    check_val("spurious_out", int'(a_out_valid), 0);
                end else begin
                    e = sb.pop_front();
                    check_val("out_cyc", cyc, e.cyc);
                    check_val("out_chan", int'(a_out_chan), e.chan);
                    check_val("out_real", int'(a_out_real), e.re);
                    check_val("out_imag", int'(a_out_imag), e.im);
                end
            end
            if (a_fader_start) begin
                check_val("t_index", int'(a_fader_t_index), int'(exp_ti));
                exp_ti = exp_ti + 25'd1;
                n_starts++;
            end
            if (b_fader_start) begin
                check_val("t_index_wrap", int'(b_fader_t_index), int'(exp_ti_wrap));
                exp_ti_wrap = exp_ti_wrap + 25'd1;
                n_starts_wrap++;
            end
            if (a_underflow) uf_cnt++;
        end
    end

    task automatic wait_starts(input int target);
        int budget = 200;
        while (n_starts < target && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        check_val("start_count", n_starts, target);
    endtask

    task automatic feed_one(input int ch, input int re, input int im);
        @(posedge clk); #1;
        fade_dv = 1'b1; fade_chan = 5'(ch); fade_real = 16'(re); fade_imag = 16'(im);
    endtask

    task automatic feed_burst(input int b, input bit decoy31);
        for (int k = 0; k < N; k++) begin
            if (decoy31 && k == 31) feed_one(k, 777, 777);
            else                    feed_one(k, b_re[b][k], b_im[b][k]);
        end
        @(posedge clk); #1;
        fade_dv = 1'b0;
    endtask

    task automatic run_frame(input bit extra_tick, input bit dv_at_rot);
        int t0;
        @(posedge clk); #1;
        sample_tick = 1'b1;
        t0 = cyc;
        for (int k = 0; k < N; k++)
            sb.push_back('{t0 + 2 + k, k, interp_exp(b_re[mp][k], b_re[mn][k], ms),
                           interp_exp(b_im[mp][k], b_im[mn][k], ms)});
        while (cyc < t0 + 40) begin
            @(posedge clk); #1;
            if (extra_tick && cyc == t0 + 6) check_val("tick_err_stream", int'(a_tick_err), 1);
            sample_tick = extra_tick && (cyc == t0 + 5);
            fade_dv = dv_at_rot && (cyc == t0 + 33);
            if (fade_dv) begin
                fade_chan = 5'd31; fade_real = 16'sd555; fade_imag = 16'sd555;
            end
        end
        sample_tick = 1'b0;
        fade_dv = 1'b0;
        check_val("frame_drain", sb.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin : stim
        int t0;
        for (int k = 0; k < N; k++) begin
            b_re[0][k] = 100 * k;        b_im[0][k] = -100 * k;
            b_re[1][k] = 100 * k + 160;  b_im[1][k] = -(100 * k + 160);
            b_re[2][k] = (k == 31) ? 0 : 100 * k + 320;
            b_im[2][k] = (k == 31) ? 0 : -(100 * k + 320);
            b_re[3][k] = (k == 31) ? -1 : 100 * k + 480;
            b_im[3][k] = (k == 31) ? 1 : -(100 * k + 480);
        end
        exp_ti = '0;
        exp_ti_wrap = T2;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_out_valid", int'(a_out_valid), 0);
        check_val("rst_fader_start", int'(a_fader_start), 0);
        check_val("rst_t_index", int'(a_fader_t_index), 0);
        check_val("rst_underflow", int'(a_underflow), 0);
        check_val("rst_tick_err", int'(a_tick_err), 0);
        check_val("rst_out_real", int'(a_out_real), 0);
        reset = 1'b0;
        wait_starts(1);

        @(posedge clk); #1; sample_tick = 1'b1;
        @(posedge clk); #1; sample_tick = 1'b0;
        check_val("tick_err_prime", int'(a_tick_err), 1);

        feed_burst(0, 1'b0);
        wait_starts(2);
        feed_burst(1, 1'b0);
        wait_starts(3);
        mp = 0; mn = 1; ms = 0;

        for (int f = 0; f < 16; f++) begin
            run_frame(f == 3, 1'b0);
            if (ms < 15) ms++;
        end
        check_val("uf_after_16", uf_cnt, 1);
        check_val("starts_after_16", n_starts, 3);
        run_frame(1'b0, 1'b0);
        check_val("uf_after_17", uf_cnt, 2);
        check_val("starts_after_17", n_starts, 3);

        feed_burst(2, 1'b0);
        run_frame(1'b0, 1'b1);
        wait_starts(4);
        check_val("wrap_t_index", int'(b_fader_t_index), 0);
        mp = 1; mn = 2; ms = 0;

        for (int f = 0; f < 16; f++) begin
            run_frame(1'b0, 1'b0);
            if (f == 1) begin
                feed_burst(3, 1'b1);
                feed_one(31, -1, 1);
                @(posedge clk); #1; fade_dv = 1'b0;
            end
            if (ms < 15) ms++;
        end
        wait_starts(5);
        check_val("uf_steady", uf_cnt, 2);
        mp = 2; mn = 3; ms = 0;

        for (int f = 0; f < 9; f++) begin
            run_frame(1'b0, 1'b0);
            ms++;
        end

        @(posedge clk); #1;
        sample_tick = 1'b1;
        t0 = cyc;
        for (int k = 0; k < 8; k++)
            sb.push_back('{t0 + 2 + k, k, interp_exp(b_re[mp][k], b_re[mn][k], ms),
                           interp_exp(b_im[mp][k], b_im[mn][k], ms)});
        @(posedge clk); #1;
        sample_tick = 1'b0;
        while (cyc < t0 + 10) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        exp_ti = '0;
        exp_ti_wrap = T2;
        check_val("pre_reset_drain", sb.size(), 0);
        sb.delete();
        @(posedge clk); #1;
        check_val("reset_out_valid", int'(a_out_valid), 0);
        reset = 1'b0;
        wait_starts(6);
        repeat (5) @(posedge clk);
        #1;
        check_val("final_drain", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
